// File: rtl/mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// mult_div_ctrl
//   Iterative signed 32x32 multiplier (radix-2 Booth) and signed 32/32
//   divider (restoring, on magnitudes) sharing one 65-bit accumulator.
//   One iteration per clock, 32 iterations, commit on the following edge.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous active-low reset
//   start_mult : request signed multiply op_a * op_b (wins over start_div)
//   start_div  : request signed divide op_a / op_b
//   op_a, op_b : operands, sampled only on the acceptance edge in IDLE
//   hi, lo     : registered result (product[63:32]/[31:0] or rem/quot)
//   busy       : operation in progress
//   done       : one-cycle pulse when hi/lo hold a new result
//   div_zero   : one-cycle pulse on divide by zero (exception build only)
//
// Configuration
//   MULTDIV_DIVZERO_EXC_EN : when defined, a divide with op_b == 0 skips the
//   iterations, leaves hi/lo untouched and pulses div_zero together with
//   done. When undefined, div_zero is tied low and divide by zero runs the
//   normal path (quotient all ones in magnitude, remainder = op_a).
// ---------------------------------------------------------------------------
module mult_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  // Multiply: {A[31:0], Q[31:0], q_minus1}. Divide: {R[32:0], Q[31:0]}.
  logic [64:0] acc_reg;
  logic [31:0] m_reg;       // multiplicand, or divisor magnitude
  logic        is_div_reg;
  logic        neg_q_reg;   // quotient sign at commit
  logic        neg_r_reg;   // remainder sign at commit
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;
  logic        div_zero_start;
  logic        commit_en;

  logic [31:0] abs_a, abs_b;
  assign abs_a = op_a[31] ? (32'd0 - op_a) : op_a;
  assign abs_b = op_b[31] ? (32'd0 - op_b) : op_b;

  // Booth step. A is sign-extended to 33 bits so that subtracting the most
  // negative multiplicand cannot overflow; the 33-bit sum's MSB then becomes
  // the correct sign bit after the arithmetic right shift.
  logic [32:0] booth_a, booth_m, booth_sum;
  logic [64:0] booth_next;
  always_comb begin
    booth_a = {acc_reg[64], acc_reg[64:33]};
    booth_m = {m_reg[31], m_reg};
    case (acc_reg[1:0])
      2'b01:   booth_sum = booth_a + booth_m;
      2'b10:   booth_sum = booth_a - booth_m;
      default: booth_sum = booth_a;
    endcase
    booth_next = {booth_sum, acc_reg[32:1]};
  end

  // Restoring division step: shift the next dividend bit into the partial
  // remainder, keep the difference when no borrow occurs.
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [64:0] div_next;
  always_comb begin
    div_shift = {acc_reg[63:32], acc_reg[31]};
    div_trial = {1'b0, div_shift} - {2'b00, m_reg};
    if (!div_trial[33])
      div_next = {div_trial[32:0], acc_reg[30:0], 1'b1};
    else
      div_next = {div_shift, acc_reg[30:0], 1'b0};
  end

  logic [31:0] quo_fix, rem_fix;
  assign quo_fix = neg_q_reg ? (32'd0 - acc_reg[31:0])  : acc_reg[31:0];
  assign rem_fix = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_mult)
          state_next = MULT;
        else if (start_div)
          state_next = div_zero_start ? DONE : DIV;
      end
      MULT, DIV: if (count_reg == 5'd31) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      acc_reg    <= '0;
      m_reg      <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          count_reg <= '0;
          if (start_mult) begin
            acc_reg    <= {32'd0, op_b, 1'b0};
            m_reg      <= op_a;
            is_div_reg <= 1'b0;
          end else if (start_div) begin
            acc_reg    <= {33'd0, abs_a};
            m_reg      <= abs_b;
            is_div_reg <= 1'b1;
            neg_q_reg  <= op_a[31] ^ op_b[31];
            neg_r_reg  <= op_a[31];
          end
        end
        MULT: begin
          acc_reg   <= booth_next;
          count_reg <= count_reg + 5'd1;
        end
        DIV: begin
          acc_reg   <= div_next;
          count_reg <= count_reg + 5'd1;
        end
        DONE: begin
          done_reg <= 1'b1;
          if (commit_en) begin
            hi_reg <= is_div_reg ? rem_fix : acc_reg[64:33];
            lo_reg <= is_div_reg ? quo_fix : acc_reg[32:1];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTDIV_DIVZERO_EXC_EN
  logic dz_reg, div_zero_reg;
  assign div_zero_start = start_div && (op_b == 32'd0);
  assign commit_en      = !dz_reg;
  assign div_zero       = div_zero_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dz_reg       <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      div_zero_reg <= (state_reg == DONE) && dz_reg;
      // Re-evaluated every idle cycle; frozen once an operation is accepted.
      if (state_reg == IDLE)
        dz_reg <= !start_mult && div_zero_start;
    end
  end
`else
  assign div_zero_start = 1'b0;
  assign commit_en      = 1'b1;
  assign div_zero       = 1'b0;
`endif

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_div_ctrl
//   Table-driven directed vectors, hand-written multi-cycle sequences
//   (ignored start mid-operation, reset mid-operation, divide by zero) and
//   randomized operations checked against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_ctrl;

  logic        clk;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected contents of hi/lo as tracked by the model.
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  typedef struct {
    bit          sm;
    bit          sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic definition of the operations.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el,
                                output int lat, output bit dz);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    eh  = last_hi;
    el  = last_lo;
    lat = 33;
    dz  = 1'b0;
    if (!is_div) begin
      p  = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
`ifdef MULTDIV_DIVZERO_EXC_EN
      lat = 1;
      dz  = 1'b1;
`else
      eh = a;
      el = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  // Issue one operation (inputs applied just after an edge so the next edge
  // is E0), then follow it until done, checking the whole timeline.
  task automatic run_op(input bit sm, input bit sd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int elat, input bit edz, input string tag);
    logic [31:0] prev_hi, prev_lo;
    int n;
    bit hold_ok, busy_ok, dz_ok;
    prev_hi = last_hi;
    prev_lo = last_lo;
    start_mult = sm;
    start_div  = sd;
    op_a = a;
    op_b = b;
    @(posedge clk); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    check({tag, "_busy_e0"}, busy, 1);
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    dz_ok   = 1'b1;
    n = 0;
    while (!done && n < 60) begin
      if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (div_zero !== 1'b0) dz_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, elat);
    check({tag, "_hold"}, hold_ok, 1);
    check({tag, "_busy_run"}, busy_ok, 1);
    check({tag, "_dz_quiet"}, dz_ok, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_div_zero"}, div_zero, edz);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    $display("op %s %s a=%h b=%h -> hi=%h lo=%h cycles=%0d", tag, sm ? "mul" : "div", a, b, hi, lo, n);
    last_hi = eh;
    last_lo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] eh, el;
    int lat, n;
    bit dz, is_div, done_seen, busy_seen;
    logic [31:0] a, b;

    vecs[0]  = '{1, 0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{0, 1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{0, 1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[5]  = '{0, 1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[6]  = '{0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[7]  = '{1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[8]  = '{1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[9]  = '{1, 1, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};
    vecs[10] = '{1, 0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{0, 1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};

    // Reset with both starts high: they must be ignored.
    reset = 1'b0;
    start_mult = 1'b1;
    start_div  = 1'b1;
    op_a = 32'd3;
    op_b = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_div_zero", div_zero, 0);
    reset = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Directed vectors, issued back to back (each start lands in the done cycle).
    foreach (vecs[i])
      run_op(vecs[i].sm, vecs[i].sd, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el,
             33, 1'b0, $sformatf("vec%0d", i));

    // done is a single-cycle pulse.
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("idle_after_done", busy, 0);

    // Divide by zero after a known result.
    run_op(1, 0, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0, "pre_dz");
    model(1'b1, 32'd5, 32'd0, eh, el, lat, dz);
    run_op(0, 1, 32'd5, 32'd0, eh, el, lat, dz, "dz_pos");
    model(1'b1, 32'hFFFF_FFF7, 32'd0, eh, el, lat, dz);
    run_op(0, 1, 32'hFFFF_FFF7, 32'd0, eh, el, lat, dz, "dz_neg");

    // start_div at E10 of a running multiply is ignored.
    start_mult = 1'b1;
    op_a = 32'd3;
    op_b = 32'd5;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    start_div = 1'b1;
    op_a = 32'd100;
    op_b = 32'd7;
    @(posedge clk); #1;
    start_div = 1'b0;
    check("ign_busy", busy, 1);
    n = 10;
    while (!done && n < 60) begin @(posedge clk); #1; n++; end
    check("ign_latency", n, 33);
    check("ign_hi", hi, 0);
    check("ign_lo", lo, 15);
    $display("op ign mul a=00000003 b=00000005 -> hi=%h lo=%h cycles=%0d", hi, lo, n);

    // Second operation reset at E20, with a start held during reset.
    start_mult = 1'b1;
    op_a = 32'h0000_1234;
    op_b = 32'h0000_5678;
    @(posedge clk); #1;
    start_mult = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("mid_busy_e19", busy, 1);
    reset = 1'b0;
    start_mult = 1'b1;
    op_a = 32'd9;
    op_b = 32'd9;
    @(posedge clk); #1;
    reset = 1'b1;
    start_mult = 1'b0;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_div_zero", div_zero, 0);
    check("mid_reset_hi", hi, 0);
    check("mid_reset_lo", lo, 0);
    done_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      done_seen |= done;
      busy_seen |= busy;
    end
    check("discarded_done", done_seen, 0);
    check("discarded_busy", busy_seen, 0);
    $display("op mid_reset hi=%h lo=%h busy=%b", hi, lo, busy);
    last_hi = '0;
    last_lo = '0;

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      model(is_div, a, b, eh, el, lat, dz);
      run_op(!is_div, is_div, a, b, eh, el, lat, dz, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock, all state updates on rising edge.
REQ-002 SHALL provide port reset, input, 1, synchronous active-low reset (reset=0 resets on the next clk rising edge).
REQ-003 SHALL provide port start_mult, input, 1, request for a signed 32x32 multiply of op_a by op_b.
REQ-004 SHALL provide port start_div, input, 1, request for a signed 32/32 divide of op_a by op_b.
REQ-005 SHALL provide port op_a, input, 32, multiplicand or dividend, sampled only at acceptance.
REQ-006 SHALL provide port op_b, input, 32, multiplier or divisor, sampled only at acceptance.
REQ-007 SHALL provide port hi, output, 32, registered HI: product[63:32] or remainder.
REQ-008 SHALL provide port lo, output, 32, registered LO: product[31:0] or quotient.
REQ-009 SHALL provide port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL provide port done, output, 1, one-cycle pulse when hi/lo hold a new result.
REQ-011 SHALL provide port div_zero, output, 1, one-cycle pulse on divide by zero.

Function
REQ-012 SHALL implement states IDLE, MULT, DIV and DONE.
- IDLE -> MULT on start_mult; IDLE -> DIV on start_div.
- MULT/DIV -> DONE after 32 iteration edges.
- DONE -> IDLE unconditionally.
REQ-013 SHALL accept a start only in IDLE, capturing op_a and op_b on that edge (E0); starts in any other state are ignored, with no queuing.
REQ-014 SHALL give start_mult priority when start_mult and start_div are both high in IDLE.
REQ-015 SHALL perform multiply as radix-2 Booth, one step per edge E1..E32, on a 65-bit accumulator.
REQ-016 SHALL perform divide as restoring division on operand magnitudes, one quotient bit per edge E1..E32, with a 33-bit partial remainder.
REQ-017 SHALL apply divide sign fix-up at commit:
- quotient is negated when sign(op_a) XOR sign(op_b) is set;
- remainder takes the sign of op_a.
REQ-018 SHALL commit hi/lo on edge E33 and drive done=1 for exactly the cycle following E33.
REQ-019 SHALL hold busy=1 from the cycle after E0 through the cycle after E32, and busy=0 while done=1.
REQ-020 SHALL leave hi/lo unchanged outside commit edges.
REQ-021 SHALL treat 0x80000000 / 0xFFFFFFFF as wrap-around, giving lo=0x80000000 and hi=0.
REQ-022 SHALL allow a new start in the cycle after done (back-to-back issue every 34 cycles).

Reset
REQ-023 SHALL, when reset=0 on a rising edge in any state, including mid-operation:
- enter IDLE;
- clear hi, lo and all internal accumulators to 0;
- drive busy, done and div_zero to 0;
- discard any in-flight operation.
REQ-024 SHALL ignore start_mult and start_div on any edge where reset=0.

Configuration
REQ-025 SHALL honour macro MULTDIV_DIVZERO_EXC_EN.
REQ-026 SHALL, with MULTDIV_DIVZERO_EXC_EN defined, handle start_div with op_b=0 as follows:
- go IDLE -> DONE at E0;
- pulse done=1 and div_zero=1 together in the cycle after E1;
- leave hi/lo unchanged.
REQ-027 SHALL, without MULTDIV_DIVZERO_EXC_EN, tie div_zero to 0 and run divide-by-zero through the normal 32-step path, giving:
- hi = op_a;
- lo = 0xFFFFFFFF if op_a >= 0, otherwise 0x00000001.

Verification
REQ-028 SHALL cover: start_mult, op_a=7, op_b=0xFFFFFFFD -> done in the cycle after E33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-029 SHALL cover: start_mult, op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-030 SHALL cover: start_div, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done in the cycle after E33.
REQ-031 SHALL cover: start_div, op_b=0 with the macro defined -> done=div_zero=1 in the cycle after E1, hi/lo keep their prior values; without the macro, op_a=5 -> hi=5, lo=0xFFFFFFFF after 34 cycles.
REQ-032 SHALL cover: start_div asserted at E10 of a running multiply, followed by reset=0 at E20 of a second operation -> the start is ignored with the first result unaffected; after the reset edge state is IDLE, hi=lo=0, busy=done=0.
